sc_counter_et: RTL and testbench

- Stochastic-to-binary converter, the receive end of the LFSR SNG bitstream interface.
- Accumulates the ones in NUM_INPUTS parallel stochastic bitstreams over a run of 2^prec cycles, then presents scaled binary estimates with a valid/ready handshake.
- Supports per-run precision (early termination: fewer cycles, fewer result bits) and abort.
- Sits downstream of the SNG / SC arithmetic and feeds binary consumers or the test bench.

---
 rtl/sc_counter_et.sv | 133 +++++++++++++
 tb/tb_sc_counter_et.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_counter_et.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sc_counter_et
// Purpose  : Stochastic-to-binary converter. Counts ones on NUM_INPUTS parallel
//            bitstreams over 2^prec cycles, then presents results scaled to the
//            2^WIDTH range behind a valid/ready handshake. Supports early
//            termination (reduced prec) and abort.
// Revision : 1.0 - initial release
// ============================================================================
module sc_counter_et #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(WIDTH+1)-1:0]        prec,
  input  logic                              abort,
  input  logic [NUM_INPUTS-1:0]             Xs,
  output logic                              busy,
  output logic                              valid,
  input  logic                              ready,
  output logic [NUM_INPUTS*(WIDTH+1)-1:0]   Zs,
  output logic [WIDTH:0]                    cycles
);

  localparam int              PW         = $clog2(WIDTH+1);
  localparam logic [PW-1:0]   C_PREC_MAX = PW'(WIDTH);

  typedef logic [WIDTH:0] cnt_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [PW-1:0]                 prec_q, prec_d;
  cnt_t                          cyc_q, cyc_d;
  logic [NUM_INPUTS-1:0][WIDTH:0] cnt_q, cnt_d;
  logic [NUM_INPUTS-1:0][WIDTH:0] zs_q, zs_d;
  cnt_t                          cycles_q, cycles_d;

  // Helpers: next cycle count, run length target and output scaling shift
  cnt_t          w_cyc_inc;
  cnt_t          w_target;
  logic [PW-1:0] w_shamt;
  logic [PW-1:0] w_prec_eff;

  assign w_cyc_inc  = cyc_q + cnt_t'(1);
  assign w_target   = cnt_t'(1) << prec_q;
  assign w_shamt    = C_PREC_MAX - prec_q;
  // Out-of-range precision (0 or above WIDTH) falls back to full precision
  assign w_prec_eff = (prec != '0 && prec <= C_PREC_MAX) ? prec : C_PREC_MAX;

  // Next-state and datapath update; abort wins over completion on the same edge
  always_comb begin
    state_d  = state_q;
    prec_d   = prec_q;
    cyc_d    = cyc_q;
    cnt_d    = cnt_q;
    zs_d     = zs_q;
    cycles_d = cycles_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          prec_d  = w_prec_eff;
          cyc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_d[i] = cnt_q[i] + cnt_t'(Xs[i]);
          end
          cyc_d = w_cyc_inc;
          if (w_cyc_inc == w_target) begin
            state_d = S_DONE;
            for (int i = 0; i < NUM_INPUTS; i++) begin
              zs_d[i] = cnt_d[i] << w_shamt;
            end
            cycles_d = w_cyc_inc;
          end
        end
      end
      S_DONE: begin
        if (ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters and held results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prec_q   <= '0;
      cyc_q    <= '0;
      cnt_q    <= '0;
      zs_q     <= '0;
      cycles_q <= '0;
    end else begin
      prec_q   <= prec_d;
      cyc_q    <= cyc_d;
      cnt_q    <= cnt_d;
      zs_q     <= zs_d;
      cycles_q <= cycles_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign valid  = (state_q == S_DONE);
  assign Zs     = zs_q;
  assign cycles = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_counter_et.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sc_counter_et
// Purpose  : Directed self-checking bench for sc_counter_et (WIDTH=8, 2 inputs)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_counter_et;

  localparam int WIDTH = 8;
  localparam int NI    = 2;
  localparam int PW    = $clog2(WIDTH+1);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [PW-1:0]            prec;
  logic                     abort;
  logic [NI-1:0]            Xs;
  logic                     busy;
  logic                     valid;
  logic                     ready;
  logic [NI*(WIDTH+1)-1:0]  Zs;
  logic [WIDTH:0]           cycles;

  int n_cmp = 0;
  int n_err = 0;

  sc_counter_et #(.WIDTH(WIDTH), .NUM_INPUTS(NI)) dut (
    .clk(clk), .rst(rst), .start(start), .prec(prec), .abort(abort),
    .Xs(Xs), .busy(busy), .valid(valid), .ready(ready), .Zs(Zs),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] zs(input int i);
    return Zs[i*(WIDTH+1) +: (WIDTH+1)];
  endfunction

  // Present start with a precision; returns at the negedge before the first RUN edge
  task automatic do_start(input logic [PW-1:0] p);
    @(negedge clk);
    start = 1'b1;
    prec  = p;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive Xs for n RUN cycles from a constant pattern; returns busy-high count
  task automatic run_const(input int n, input logic [NI-1:0] x, output int nbusy);
    nbusy = 0;
    for (int k = 0; k < n; k++) begin
      Xs = x;
      if (busy === 1'b1 && valid === 1'b0) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic handshake;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL handshake_valid_low: got %b want 0", valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; prec = '0; abort = 1'b0; Xs = '0; ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (Zs !== '0)       begin n_err++; $display("FAIL reset_zs: got %h want 0", Zs); end
    n_cmp++; if (cycles !== '0)   begin n_err++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_prec;
    int nb;
    do_start(4'd8);
    run_const(256, 2'b01, nb);
    n_cmp++; if (nb != 256)          begin n_err++; $display("FAIL p8_busy_cycles: got %0d want 256", nb); end
    n_cmp++; if (valid !== 1'b1)     begin n_err++; $display("FAIL p8_valid: got %b want 1", valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL p8_busy_low: got %b want 0", busy); end
    n_cmp++; if (zs(0) !== 9'd256)   begin n_err++; $display("FAIL p8_zs0: got %0d want 256", zs(0)); end
    n_cmp++; if (zs(1) !== 9'd0)     begin n_err++; $display("FAIL p8_zs1: got %0d want 0", zs(1)); end
    n_cmp++; if (cycles !== 9'd256)  begin n_err++; $display("FAIL p8_cycles: got %0d want 256", cycles); end
    handshake();
  endtask

  task automatic test_prec4;
    int nb;
    nb = 0;
    do_start(4'd4);
    for (int k = 0; k < 16; k++) begin
      Xs[0] = (k % 2 == 0);
      Xs[1] = (k == 2 || k == 7 || k == 11);
      if (busy === 1'b1) nb++;
      @(negedge clk);
    end
    n_cmp++; if (nb != 16)          begin n_err++; $display("FAIL p4_busy_cycles: got %0d want 16", nb); end
    n_cmp++; if (valid !== 1'b1)    begin n_err++; $display("FAIL p4_valid: got %b want 1", valid); end
    n_cmp++; if (zs(0) !== 9'd128)  begin n_err++; $display("FAIL p4_zs0: got %0d want 128", zs(0)); end
    n_cmp++; if (zs(1) !== 9'd48)   begin n_err++; $display("FAIL p4_zs1: got %0d want 48", zs(1)); end
    n_cmp++; if (cycles !== 9'd16)  begin n_err++; $display("FAIL p4_cycles: got %0d want 16", cycles); end
    handshake();
  endtask

  task automatic test_prec_clamp;
    logic [PW-1:0] plist [2];
    int nb;
    plist[0] = 4'd0;
    plist[1] = 4'd15;
    for (int t = 0; t < 2; t++) begin
      do_start(plist[t]);
      run_const(256, 2'b01, nb);
      n_cmp++; if (nb != 256)         begin n_err++; $display("FAIL clamp%0d_busy_cycles: got %0d want 256", plist[t], nb); end
      n_cmp++; if (valid !== 1'b1)    begin n_err++; $display("FAIL clamp%0d_valid: got %b want 1", plist[t], valid); end
      n_cmp++; if (zs(0) !== 9'd256)  begin n_err++; $display("FAIL clamp%0d_zs0: got %0d want 256", plist[t], zs(0)); end
      n_cmp++; if (cycles !== 9'd256) begin n_err++; $display("FAIL clamp%0d_cycles: got %0d want 256", plist[t], cycles); end
      handshake();
    end
  endtask

  task automatic test_hold;
    logic [NI-1:0] pat [4];
    int bad;
    int nb;
    pat[0] = 2'b10; pat[1] = 2'b11; pat[2] = 2'b00; pat[3] = 2'b01;
    do_start(4'd2);
    for (int k = 0; k < 4; k++) begin
      Xs = pat[k];
      @(negedge clk);
    end
    // counts: stream0 = 2, stream1 = 2 over 4 cycles -> 2 << 6 = 128
    n_cmp++; if (valid !== 1'b1)    begin n_err++; $display("FAIL hold_valid_rise: got %b want 1", valid); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      Xs    = NI'(k);
      start = k[0];
      @(negedge clk);
      if (valid !== 1'b1 || zs(0) !== 9'd128 || zs(1) !== 9'd128 || cycles !== 9'd4) bad++;
    end
    start = 1'b0;
    n_cmp++; if (bad != 0)          begin n_err++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
    // handshake with start high: start must be ignored
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    start = 1'b0;
    n_cmp++; if (valid !== 1'b0)    begin n_err++; $display("FAIL hold_valid_drop: got %b want 0", valid); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL hold_start_ignored: busy got %b want 0", busy); end
    do_start(4'd1);
    run_const(2, 2'b11, nb);
    n_cmp++; if (valid !== 1'b1)    begin n_err++; $display("FAIL hold_rerun_valid: got %b want 1", valid); end
    n_cmp++; if (zs(0) !== 9'd256 || zs(1) !== 9'd256) begin
      n_err++; $display("FAIL hold_rerun_zs: got %0d/%0d want 256/256", zs(0), zs(1));
    end
    n_cmp++; if (cycles !== 9'd2)   begin n_err++; $display("FAIL hold_rerun_cycles: got %0d want 2", cycles); end
    handshake();
  endtask

  task automatic test_abort;
    int bad;
    // abort at RUN cycle 5 of a prec=8 run
    do_start(4'd8);
    for (int k = 0; k < 5; k++) begin
      Xs = 2'b00;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL abort5_busy: got %b want 0", busy); end
    bad = 0;
    for (int k = 0; k < 260; k++) begin
      if (valid !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++; if (bad != 0)          begin n_err++; $display("FAIL abort5_no_valid: got %0d valid cycles want 0", bad); end
    n_cmp++; if (zs(0) !== 9'd256 || zs(1) !== 9'd256) begin
      n_err++; $display("FAIL abort5_zs_kept: got %0d/%0d want 256/256", zs(0), zs(1));
    end
    // abort on the final counting edge of a prec=2 run
    do_start(4'd2);
    for (int k = 0; k < 4; k++) begin
      Xs    = 2'b00;
      abort = (k == 3);
      @(negedge clk);
    end
    abort = 1'b0;
    n_cmp++; if (valid !== 1'b0)    begin n_err++; $display("FAIL abort_last_valid: got %b want 0", valid); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL abort_last_busy: got %b want 0", busy); end
    n_cmp++; if (zs(0) !== 9'd256 || zs(1) !== 9'd256) begin
      n_err++; $display("FAIL abort_last_zs_kept: got %0d/%0d want 256/256", zs(0), zs(1));
    end
    n_cmp++; if (cycles !== 9'd2)   begin n_err++; $display("FAIL abort_last_cycles_kept: got %0d want 2", cycles); end
  endtask

  task automatic test_async_reset;
    int nb;
    do_start(4'd8);
    run_const(20, 2'b11, nb);
    #2;
    rst = 1'b1;
    #0.5;
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_cmp++; if (valid !== 1'b0)    begin n_err++; $display("FAIL arst_valid: got %b want 0", valid); end
    n_cmp++; if (Zs !== '0)         begin n_err++; $display("FAIL arst_zs: got %h want 0", Zs); end
    n_cmp++; if (cycles !== '0)     begin n_err++; $display("FAIL arst_cycles: got %0d want 0", cycles); end
    #0.5;
    rst = 1'b0;
    do_start(4'd1);
    run_const(2, 2'b11, nb);
    n_cmp++; if (valid !== 1'b1)    begin n_err++; $display("FAIL arst_rerun_valid: got %b want 1", valid); end
    n_cmp++; if (zs(0) !== 9'd256 || zs(1) !== 9'd256) begin
      n_err++; $display("FAIL arst_rerun_zs: got %0d/%0d want 256/256", zs(0), zs(1));
    end
    n_cmp++; if (cycles !== 9'd2)   begin n_err++; $display("FAIL arst_rerun_cycles: got %0d want 2", cycles); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_full_prec();
    test_prec4();
    test_prec_clamp();
    test_hold();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
